// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per cycle, IDLE/BUSY/DONE handshake.
// Define DIVIDER_SEQ_SIGNED_EN to honour sgn (two's complement operands); otherwise all unsigned.
module divider_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sgn,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             ovfl
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             ovp_q, ovp_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovfl_q, ovfl_d;

    logic             signed_op_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic [WIDTH:0]   trial_s, diff_s;
    logic [WIDTH-1:0] acc_nx_s, sh_nx_s;

    // Operand magnitudes for the accept edge
    always_comb begin
`ifdef DIVIDER_SEQ_SIGNED_EN
        signed_op_s = sgn;
`else
        signed_op_s = sgn & 1'b0;
`endif
        mag_a_s = (signed_op_s && dividend[WIDTH-1]) ? twos_neg(dividend) : dividend;
        mag_b_s = (signed_op_s && divisor[WIDTH-1])  ? twos_neg(divisor)  : divisor;
    end

    // One restoring step: the difference's top bit set means the trial went negative
    always_comb begin
        trial_s = {acc_q, sh_q[WIDTH-1]};
        diff_s  = trial_s - {1'b0, dvs_q};
        if (!diff_s[WIDTH]) begin
            acc_nx_s = diff_s[WIDTH-1:0];
            sh_nx_s  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx_s = trial_s[WIDTH-1:0];
            sh_nx_s  = {sh_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovp_d   = ovp_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovfl_d  = ovfl_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d  = {CW{1'b0}};
                    acc_d  = {WIDTH{1'b0}};
                    sh_d   = mag_a_s;
                    dvs_d  = mag_b_s;
                    qneg_d = signed_op_s & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d = signed_op_s & dividend[WIDTH-1];
                    ovp_d  = signed_op_s & (dividend == MIN_NEG) & (divisor == {WIDTH{1'b1}});
                    ovfl_d = 1'b0;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d = DONE;
                        quo_d   = {WIDTH{1'b1}};
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = BUSY;
                        dz_d    = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d = acc_nx_s;
                sh_d  = sh_nx_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = {CW{1'b0}};
                    quo_d   = qneg_q ? twos_neg(sh_nx_s)  : sh_nx_s;
                    rem_d   = rneg_q ? twos_neg(acc_nx_s) : acc_nx_s;
                    ovfl_d  = ovp_q;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            sh_q    <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovp_q   <= 1'b0;
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dz_q    <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovp_q   <= ovp_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovfl_q  <= ovfl_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dz        = dz_q;
    assign ovfl      = ovfl_q;

endmodule

// File: tb/tb_divider_seq.sv
// Randomised self-checking bench for divider_seq (WIDTH=16) against an arithmetic reference model.
module tb_divider_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         sgn;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;
    logic         ovfl;

    int n_chk  = 0;
    int n_fail = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .sgn       (sgn),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovfl      (ovfl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SV '/' and '%' truncate toward zero as required.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output logic o);
        logic sm;
        int   sa, sb;
`ifdef DIVIDER_SEQ_SIGNED_EN
        sm = s;
`else
        sm = s & 1'b0;
`endif
        z = 1'b0;
        o = 1'b0;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else if (sm && a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000;
            r = 16'd0;
            o = 1'b1;
        end else if (sm) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                                input logic ez, input logic eo);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(dz), 32'(ez));
        check({tag, "_ovfl"}, 32'(ovfl), 32'(eo));
    endtask

    // Runs one division; the caller is mid-cycle. hold = cycles of out_ready=0 in DONE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int hold);
        logic [W-1:0] eq, er;
        logic         ez, eo;
        int           lat;
        model(a, b, s, eq, er, ez, eo);
        check({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sgn      = s;
        out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        // Inputs churn during BUSY and start pulses randomly; none of it may matter
        while (!out_valid && lat < 40) begin
            start    = 1'($urandom_range(0, 1));
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            sgn      = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), (b == 16'd0) ? 32'd1 : 32'(W + 1));
        check_result(tag, eq, er, ez, eo);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
            check_result({tag, "_hold"}, eq, er, ez, eo);
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, "_exit_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_exit_inrdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = 16'd0;
        divisor   = 16'd0;
        sgn       = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_inrdy", 32'(in_ready), 32'd1);
        check("rst_vld", 32'(out_valid), 32'd0);
        check_result("rst", 16'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_op("udiv_100_7", 16'd100, 16'd7, 1'b0, 0);
        run_op("dz_1234", 16'h1234, 16'h0000, 1'b0, 1);
        run_op("bp_5", 16'd54321, 16'd123, 1'b0, 5);
        run_op("sgn_m7_2", 16'hFFF9, 16'd2, 1'b1, 0);
        run_op("sgn_ovf", 16'h8000, 16'hFFFF, 1'b1, 2);
        run_op("udiv_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op("udiv_small", 16'd3, 16'hFFFF, 1'b1, 0);

        // Abort partway through BUSY
        start    = 1'b1;
        dividend = 16'hBEEF;
        divisor  = 16'd5;
        sgn      = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #2;
        check("mid_rst_inrdy", 32'(in_ready), 32'd1);
        check("mid_rst_vld", 32'(out_valid), 32'd0);
        check_result("mid_rst", 16'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        check("mid_rst_noval", 32'(seen_valid), 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b;
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'hFFFF - 16'($urandom_range(0, 7));
                default: b = 16'($urandom);
            endcase
            run_op($sformatf("rnd%0d", n), a, b, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (even, >=4).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a division; accepted only when in_ready=1.
REQ-005 SHALL have port: dividend  input  WIDTH  numerator, sampled on the accept edge.
REQ-006 SHALL have port: divisor  input  WIDTH  denominator, sampled on the accept edge.
REQ-007 SHALL have port: sgn  input  1  signed-operation request, sampled on the accept edge.
REQ-008 SHALL have port: in_ready  output  1  high only in IDLE.
REQ-009 SHALL have port: out_valid  output  1  result available, high only in DONE.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have ports: quotient, remainder  output  WIDTH each  registered results.
REQ-012 SHALL have port: dz  output  1  divide-by-zero flag, valid with out_valid.
REQ-013 SHALL have port: ovfl  output  1  signed overflow flag, valid with out_valid.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-015 In IDLE, start=1 SHALL capture the operands and move to BUSY with the iteration counter at 0 on the same edge.
REQ-016 In BUSY, each cycle SHALL run one restoring step: shift the partial remainder left by one, bring in the next dividend MSB, subtract the divisor, keep the difference and set the quotient bit to 1 if it is non-negative, else restore.
REQ-017 After exactly WIDTH BUSY cycles the FSM SHALL enter DONE, so out_valid rises on the (WIDTH+1)th edge counting the accept edge.
REQ-018 If divisor=0 at accept, the FSM SHALL skip BUSY and go straight to DONE with quotient all ones, remainder = dividend, dz=1; out_valid rises on the edge after accept.
REQ-019 In DONE, the outputs SHALL hold stable until out_valid and out_ready are both 1 on an edge, then move to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE; start SHALL be ignored outside IDLE, including while BUSY.
REQ-021 start SHALL NOT be accepted on the edge that leaves DONE; the earliest new accept is one cycle later.
REQ-022 In unsigned mode, quotient SHALL equal floor(dividend/divisor) and remainder SHALL equal dividend mod divisor; ovfl SHALL be 0.
REQ-023 dz and ovfl SHALL be cleared on every accept.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, counter 0, in_ready=1 and out_valid=0, and clear quotient, remainder, dz and ovfl to 0.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation; no result SHALL be presented after release.
REQ-026 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-027 With DIVIDER_SEQ_SIGNED_EN defined and sgn=1, operands SHALL be two's complement: magnitudes are divided, the quotient is negated when operand signs differ, and the remainder takes the dividend's sign.
REQ-028 With DIVIDER_SEQ_SIGNED_EN defined, signed -2^(WIDTH-1) / -1 SHALL give quotient = -2^(WIDTH-1), remainder 0 and ovfl=1.
REQ-029 Without DIVIDER_SEQ_SIGNED_EN, sgn SHALL be ignored, all operations SHALL be unsigned, and ovfl SHALL be constant 0.
REQ-030 Latency SHALL be identical with and without the macro.

Verification (WIDTH=16)
REQ-031 Unsigned test: 100/7 with out_ready=1 SHALL give quotient=14, remainder=2, out_valid high after the 17th edge counting accept, and in_ready=1 on the next edge.
REQ-032 Divide-by-zero test: 0x1234/0 SHALL give quotient=0xFFFF, remainder=0x1234, dz=1, and out_valid on the edge after accept.
REQ-033 Backpressure test: with out_ready=0 for 5 cycles in DONE, outputs SHALL stay stable and in_ready=0; start pulses during BUSY and DONE SHALL have no effect.
REQ-034 Mid-operation reset test: pulsing rst_n low at BUSY cycle 8 SHALL return all outputs to 0 with in_ready=1, and no out_valid SHALL follow.
REQ-035 Signed test (macro defined, sgn=1): -7/2 SHALL give quotient=-3, remainder=-1; 0x8000/0xFFFF SHALL give quotient=0x8000, remainder=0, ovfl=1.
REQ-036 Macro-absent test: sgn=1 with 0xFFF9/2 SHALL give quotient=0x7FFC, remainder=1, ovfl=0.
